fetch_unit: RTL

//   Instruction fetch stage: owns the program counter and drives the word address into the

---
 rtl/fetch_unit.sv | 90 +++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, combinational ROM addressing, and IF/ID register with valid/ready.
// Optional `IFETCH_MISALIGN_CHECK_EN adds fault_o for misaligned redirect targets.
module fetch_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     IMEM_WORDS = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_inst_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o,
  output logic            valid_o,
`ifdef IFETCH_MISALIGN_CHECK_EN
  output logic            fault_o,
`endif
  input  logic            ready_i
);

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_pc_out;
  logic            r_valid;

  logic [XLEN-1:0] w_word_idx;
  logic [XLEN-1:0] w_fetch_word;
  logic [XLEN-1:0] w_target;
  logic            w_advance;
  logic            w_misalign;
  logic            w_can_fetch;

  assign w_word_idx   = {2'b00, r_pc[XLEN-1:2]};
  assign imem_addr_o  = w_word_idx;
  // Out-of-range indices never forward ROM data, so X cannot reach decode.
  assign w_fetch_word = (w_word_idx < XLEN'(IMEM_WORDS)) ? imem_inst_i : NOP;
  assign w_target     = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign w_advance    = !r_valid || ready_i;

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic r_fault;

  assign w_misalign  = |redirect_pc_i[1:0];
  assign w_can_fetch = !r_fault;
  assign fault_o     = r_fault;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fault <= 1'b0;
    end else if (redirect_i && w_misalign) begin
      r_fault <= 1'b1;
    end
  end
`else
  logic w_unused_lsbs;

  assign w_misalign    = 1'b0;
  assign w_can_fetch   = 1'b1;
  assign w_unused_lsbs = ^redirect_pc_i[1:0];
`endif

  // Redirect outranks both stall and handshake: the held word is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc     <= RESET_PC;
      r_valid  <= 1'b0;
      r_inst   <= NOP;
      r_pc_out <= '0;
    end else if (redirect_i) begin
      r_valid <= 1'b0;
      if (!w_misalign) begin
        r_pc <= w_target;
      end
    end else if (w_can_fetch && w_advance) begin
      r_inst   <= w_fetch_word;
      r_pc_out <= r_pc;
      r_valid  <= 1'b1;
      r_pc     <= r_pc + XLEN'(4);
    end
  end

  assign inst_o  = r_inst;
  assign pc_o    = r_pc_out;
  assign valid_o = r_valid;

endmodule
